// File: rtl/cic_channel_scheduler_if.sv
// Control/status bundle between the PDM/CIC timing generator (master) and
// the channel scheduler (slave).
interface cic_channel_scheduler_if #(
  parameter int CHANNELS   = 8,
  parameter int STAGES     = 3,
  parameter int DATA_WIDTH = 16
);
  localparam int CHANNELS_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int STAGE_WIDTH    = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                      read_enable;
  logic                      comb_enable;
  logic                      cfg_we;
  logic [DATA_WIDTH-1:0]     cfg_sample_rate;
  logic                      overrun_clr;
  logic [CHANNELS_WIDTH-1:0] channel;
  logic [STAGE_WIDTH-1:0]    stage;
  logic                      integ_step;
  logic                      comb_step;
  logic                      out_we;
  logic                      cic_finish;
  logic                      busy;
  logic                      overrun;
  logic [DATA_WIDTH-1:0]     sample_rate;

  modport master (
    output read_enable, comb_enable, cfg_we, cfg_sample_rate, overrun_clr,
    input  channel, stage, integ_step, comb_step, out_we, cic_finish, busy,
           overrun, sample_rate
  );

  modport slave (
    input  read_enable, comb_enable, cfg_we, cfg_sample_rate, overrun_clr,
    output channel, stage, integ_step, comb_step, out_we, cic_finish, busy,
           overrun, sample_rate
  );
endinterface

// File: rtl/cic_channel_scheduler.sv
// Sequences the shared CIC integrator/comb datapath over all channels once
// per PDM period and owns the sample_rate configuration register.
module cic_channel_scheduler #(
  parameter int CHANNELS            = 8,
  parameter int STAGES              = 3,
  parameter int DATA_WIDTH          = 16,
  parameter int DEFAULT_SAMPLE_RATE = 63
) (
  input  logic                    clk,
  input  logic                    resetn,
  cic_channel_scheduler_if.slave  bus
);
  localparam int CHANNELS_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int STAGE_WIDTH    = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_INTEG, S_COMB, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CHANNELS_WIDTH-1:0] channel_q, channel_d;
  logic [STAGE_WIDTH-1:0]    stage_q, stage_d;
  logic                      start;
  logic                      comb_pend;
  logic                      integ_q, comb_q, out_we_q, finish_q, busy_q;
  logic                      overrun_q;
  logic                      pending;
  logic [DATA_WIDTH-1:0]     pending_rate;
  logic [DATA_WIDTH-1:0]     sample_rate_q;
  logic                      last_stage, last_channel, apply;

  assign last_stage   = (stage_q == STAGE_WIDTH'(STAGES - 1));
  assign last_channel = (channel_q == CHANNELS_WIDTH'(CHANNELS - 1));
  assign apply        = (state_q == S_DONE) && comb_pend && pending;

  // Next-state and channel/stage counter logic for one sweep.
  always_comb begin
    state_d   = state_q;
    channel_d = channel_q;
    stage_d   = stage_q;
    start     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.read_enable) begin
          start     = 1'b1;
          channel_d = '0;
          stage_d   = '0;
          state_d   = S_INTEG;
        end
      end
      S_INTEG: begin
        if (last_stage) begin
          stage_d = '0;
          if (comb_pend)         state_d = S_COMB;
          else if (last_channel) state_d = S_DONE;
          else                   channel_d = channel_q + CHANNELS_WIDTH'(1);
        end else begin
          stage_d = stage_q + STAGE_WIDTH'(1);
        end
      end
      S_COMB: begin
        if (last_stage) begin
          stage_d = '0;
          state_d = S_WRITE;
        end else begin
          stage_d = stage_q + STAGE_WIDTH'(1);
        end
      end
      S_WRITE: begin
        if (last_channel) begin
          state_d = S_DONE;
        end else begin
          channel_d = channel_q + CHANNELS_WIDTH'(1);
          state_d   = S_INTEG;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; step/status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= S_IDLE;
      channel_q <= '0;
      stage_q   <= '0;
      comb_pend <= 1'b0;
      integ_q   <= 1'b0;
      comb_q    <= 1'b0;
      out_we_q  <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      stage_q   <= stage_d;
      if (start) comb_pend <= bus.comb_enable;
      integ_q   <= (state_d == S_INTEG);
      comb_q    <= (state_d == S_COMB);
      out_we_q  <= (state_d == S_WRITE);
      finish_q  <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Overrun flag and sample_rate staging; apply reads the old pending_rate
  // so a write in the apply cycle stays pending for the next boundary.
  always_ff @(posedge clk) begin
    if (resetn) begin
      overrun_q     <= 1'b0;
      pending       <= 1'b0;
      pending_rate  <= DATA_WIDTH'(DEFAULT_SAMPLE_RATE);
      sample_rate_q <= DATA_WIDTH'(DEFAULT_SAMPLE_RATE);
    end else begin
      if (bus.read_enable && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (bus.overrun_clr)                   overrun_q <= 1'b0;
      if (apply) sample_rate_q <= pending_rate;
      if (bus.cfg_we) begin
        pending_rate <= bus.cfg_sample_rate;
        pending      <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  assign bus.channel     = channel_q;
  assign bus.stage       = stage_q;
  assign bus.integ_step  = integ_q;
  assign bus.comb_step   = comb_q;
  assign bus.out_we      = out_we_q;
  assign bus.cic_finish  = finish_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.sample_rate = sample_rate_q;
endmodule

// File: tb/tb_cic_channel_scheduler.sv
// Bench for cic_channel_scheduler: a queue-based sweep model checked every
// cycle, plus directed sweeps with hand-computed counts and latencies.
module tb_cic_channel_scheduler;
  localparam int NCH = 8;
  localparam int NST = 3;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cic_channel_scheduler_if #(.CHANNELS(NCH), .STAGES(NST), .DATA_WIDTH(DW)) bus ();

  cic_channel_scheduler #(
    .CHANNELS(NCH), .STAGES(NST), .DATA_WIDTH(DW), .DEFAULT_SAMPLE_RATE(63)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  // Model: a sweep is the ordered list of datapath steps it must emit.
  typedef struct {int kind; int ch; int st;} item_t; // kind 0 integ,1 comb,2 write,3 done
  item_t q[$];
  item_t cur;
  bit    cur_v  = 0;
  bit    m_comb = 0;
  bit    m_pend = 0;
  bit    m_ovr  = 0;
  int    m_prate = 63;
  int    m_sr    = 63;
  int    m_ch    = 0;
  int    cyc     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // inputs that the next rising edge will sample.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      begin
        bit e_i, e_c, e_w, e_f;
        int e_st;
        e_i  = cur_v && cur.kind == 0;
        e_c  = cur_v && cur.kind == 1;
        e_w  = cur_v && cur.kind == 2;
        e_f  = cur_v && cur.kind == 3;
        e_st = (cur_v && cur.kind < 2) ? cur.st : 0;
        total++;
        if (bus.integ_step !== e_i || bus.comb_step !== e_c || bus.out_we !== e_w ||
            bus.cic_finish !== e_f || bus.busy !== cur_v || int'(bus.channel) != m_ch ||
            int'(bus.stage) != e_st || bus.overrun !== m_ovr || int'(bus.sample_rate) != m_sr) begin
          bad++;
          $display("FAIL cycle_model@%0d: got i=%b c=%b w=%b f=%b busy=%b ch=%0d st=%0d ovr=%b sr=%0d expected i=%b c=%b w=%b f=%b busy=%b ch=%0d st=%0d ovr=%b sr=%0d",
                   cyc, bus.integ_step, bus.comb_step, bus.out_we, bus.cic_finish, bus.busy,
                   bus.channel, bus.stage, bus.overrun, bus.sample_rate,
                   e_i, e_c, e_w, e_f, cur_v, m_ch, e_st, m_ovr, m_sr);
        end
      end
      if (resetn) begin
        q.delete();
        cur_v = 0; m_comb = 0; m_pend = 0; m_ovr = 0;
        m_prate = 63; m_sr = 63; m_ch = 0;
      end else begin
        if (bus.read_enable && cur_v) m_ovr = 1;
        else if (bus.overrun_clr)     m_ovr = 0;
        if (cur_v && cur.kind == 3 && m_comb && m_pend) begin
          m_sr = m_prate; m_pend = 0;
        end
        if (bus.cfg_we) begin
          m_prate = int'(bus.cfg_sample_rate); m_pend = 1;
        end
        if (cur_v) begin
          if (q.size() > 0) begin
            cur = q.pop_front(); m_ch = cur.ch;
          end else begin
            cur_v = 0;
          end
        end else if (bus.read_enable) begin
          m_comb = bus.comb_enable;
          for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < NST; s++) q.push_back('{0, c, s});
            if (m_comb) begin
              for (int s = 0; s < NST; s++) q.push_back('{1, c, s});
              q.push_back('{2, c, 0});
            end
          end
          q.push_back('{3, NCH - 1, 0});
          cur = q.pop_front(); cur_v = 1; m_ch = cur.ch;
        end
      end
    end
  end

  task automatic clear_pulses();
    bus.read_enable = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.overrun_clr = 1'b0;
    resetn          = 1'b0;
  endtask

  // act: 0 none, 1 cfg_we(val), 2 read_enable, 3 read_enable+overrun_clr, 4 reset
  task automatic apply_act(input int act, input int val);
    case (act)
      1: begin bus.cfg_we = 1'b1; bus.cfg_sample_rate = DW'(val); end
      2: bus.read_enable = 1'b1;
      3: begin bus.read_enable = 1'b1; bus.overrun_clr = 1'b1; end
      4: resetn = 1'b1;
      default: ;
    endcase
  endtask

  // One strobe; counts steps and the cycle of cic_finish (exp_len 0 = none).
  task automatic sweep(input string nm, input bit c, input int exp_len, input int exp_i,
                       input int exp_c, input int exp_w, input int act_cycle,
                       input int act, input int val);
    int ni = 0, nc = 0, nw = 0, fin_at = 0;
    @(posedge clk); #1;
    bus.read_enable = 1'b1;
    bus.comb_enable = c;
    @(posedge clk); #1;
    clear_pulses();
    bus.comb_enable = ~c;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (bus.integ_step) ni++;
      if (bus.comb_step)  nc++;
      if (bus.out_we)     nw++;
      if (bus.cic_finish) begin
        fin_at = n;
        break;
      end
      @(posedge clk); #1;
      clear_pulses();
      if (n + 1 == act_cycle) apply_act(act, val);
    end
    @(posedge clk); #1;
    clear_pulses();
    chk({nm, "_finish_cycle"}, fin_at, exp_len);
    chk({nm, "_integ_count"}, ni, exp_i);
    chk({nm, "_comb_count"}, nc, exp_c);
    chk({nm, "_we_count"}, nw, exp_w);
  endtask

  initial begin
    bus.read_enable = 1'b0;
    bus.comb_enable = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_sample_rate = '0;
    bus.overrun_clr = 1'b0;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("reset_sample_rate", int'(bus.sample_rate), 63);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_overrun", int'(bus.overrun), 0);
    chk("reset_channel", int'(bus.channel), 0);

    sweep("plain", 0, 25, 24, 0, 0, 0, 0, 0);
    sweep("comb",  1, 57, 24, 24, 8, 0, 0, 0);

    sweep("cfg31_plain", 0, 25, 24, 0, 0, 5, 1, 31);
    @(negedge clk) chk("sr_after_plain", int'(bus.sample_rate), 63);
    sweep("cfg31_comb", 1, 57, 24, 24, 8, 0, 0, 0);
    @(negedge clk) chk("sr_after_comb", int'(bus.sample_rate), 31);

    @(posedge clk); #1 bus.cfg_we = 1'b1; bus.cfg_sample_rate = 16'd31;
    @(posedge clk); #1 bus.cfg_we = 1'b0;
    sweep("cfg15_apply", 1, 57, 24, 24, 8, 57, 1, 15);
    @(negedge clk) chk("sr_apply_old", int'(bus.sample_rate), 31);
    sweep("cfg15_next", 1, 57, 24, 24, 8, 0, 0, 0);
    @(negedge clk) chk("sr_apply_new", int'(bus.sample_rate), 15);

    sweep("ovr", 0, 25, 24, 0, 0, 10, 2, 0);
    @(negedge clk) chk("overrun_set", int'(bus.overrun), 1);
    sweep("ovr_clr_set", 0, 25, 24, 0, 0, 5, 3, 0);
    @(negedge clk) chk("overrun_set_wins", int'(bus.overrun), 1);
    @(posedge clk); #1 bus.overrun_clr = 1'b1;
    @(posedge clk); #1 bus.overrun_clr = 1'b0;
    @(negedge clk) chk("overrun_cleared", int'(bus.overrun), 0);
    sweep("ovr_done", 0, 25, 24, 0, 0, 25, 2, 0);
    @(negedge clk) begin
      chk("overrun_in_done", int'(bus.overrun), 1);
      chk("no_restart_after_done", int'(bus.busy), 0);
    end
    @(posedge clk); #1 bus.overrun_clr = 1'b1;
    @(posedge clk); #1 bus.overrun_clr = 1'b0;

    sweep("abort", 1, 0, 12, 11, 3, 26, 4, 0);
    @(negedge clk) chk("sr_after_abort", int'(bus.sample_rate), 63);
    sweep("restart", 1, 57, 24, 24, 8, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cic_channel_scheduler.md
Name: cic_channel_scheduler

Overview:
- Sequences the shared, time-multiplexed CIC integrator/comb datapath across all microphone channels within one PDM period.
- Takes the per-period start strobe and the decimation strobe from the PDM/CIC timing generator. Drives the channel index, stage index and step enables for the datapath.
- Owns the sample_rate configuration register and applies updates only at a decimation boundary.

Parameters:
CHANNELS, 8, number of microphone channels time-shared on the datapath
STAGES, 3, CIC order (integrator and comb stages per channel)
DATA_WIDTH, 16, width of the sample_rate register
DEFAULT_SAMPLE_RATE, 63, sample_rate value loaded at reset (decimation = value+1 PDM periods)
CHANNELS_WIDTH, $clog2(CHANNELS), channel index width
STAGE_WIDTH, $clog2(STAGES), stage index width (minimum 1)

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock, reset is synchronous and active-high
read_enable  in  1  one-cycle strobe: PDM bits captured, start a sweep
comb_enable  in  1  high during the PDM period that ends a decimation interval
cfg_we  in  1  write strobe for the sample_rate configuration
cfg_sample_rate  in  DATA_WIDTH  new sample_rate value
overrun_clr  in  1  clears the overrun flag
channel  out  CHANNELS_WIDTH  channel currently on the datapath
stage  out  STAGE_WIDTH  CIC stage currently on the datapath
integ_step  out  1  datapath performs integrator stage[stage] of channel
comb_step  out  1  datapath performs comb stage[stage] of channel
out_we  out  1  decimated sample of channel is valid; write to output FIFO
cic_finish  out  1  one-cycle pulse: sweep complete
busy  out  1  sweep in progress
overrun  out  1  sticky: read_enable arrived while busy
sample_rate  out  DATA_WIDTH  active decimation setting, fed to the timing generator

Behaviour:
- All outputs are registered. Reset values: channel=0, stage=0, integ_step=0, comb_step=0, out_we=0, cic_finish=0, busy=0, overrun=0, sample_rate=DEFAULT_SAMPLE_RATE. Reset also clears the pending configuration flag and comb_pend.
- Reset asserted mid-sweep aborts the sweep on the next edge. No cic_finish or out_we is produced for the aborted sweep.
- States: S_IDLE, S_INTEG, S_COMB, S_WRITE, S_DONE.
- S_IDLE:
  - read_enable=1: latch comb_pend<=comb_enable, channel<=0, stage<=0, go to S_INTEG.
  - First integ_step is visible the cycle after the strobe (latency 1).
- S_INTEG:
  - integ_step=1, busy=1; stage increments each cycle.
  - At stage==STAGES-1: stage<=0.
    - comb_pend=1: go to S_COMB.
    - Otherwise, channel==CHANNELS-1: go to S_DONE.
    - Otherwise: channel+1, remain in S_INTEG.
- S_COMB: comb_step=1, busy=1; stage increments. At stage==STAGES-1: stage<=0, go to S_WRITE.
- S_WRITE: out_we=1 for exactly one cycle. Then channel==CHANNELS-1 goes to S_DONE; otherwise channel+1, go to S_INTEG.
- S_DONE:
  - cic_finish=1 for one cycle; busy=1; channel holds CHANNELS-1; go to S_IDLE.
  - busy deasserts in S_IDLE.
- integ_step, comb_step and out_we are mutually exclusive.
- Sweep length from strobe to cic_finish inclusive:
  - Without comb: CHANNELS*STAGES+1 cycles (25 at defaults).
  - With comb: CHANNELS*(2*STAGES+1)+1 cycles (57 at defaults).
- read_enable while busy (including S_DONE): strobe ignored, sweep continues unchanged, overrun<=1.
- overrun_clr clears overrun. If overrun_clr and a new overrun occur in the same cycle, set wins.
- Configuration:
  - cfg_we loads pending_rate<=cfg_sample_rate and sets pending=1. A later cfg_we before apply overwrites pending_rate (last write wins).
  - Apply happens in the S_DONE cycle of a sweep with comb_pend=1: sample_rate<=pending_rate, pending<=0.
  - cfg_we in the same cycle as apply: the old pending_rate is applied, the new value is stored, and pending stays 1.
  - Sweeps without comb never change sample_rate.
- comb_enable is sampled only at the start strobe. Changes mid-sweep have no effect.

Test Plan:
- Reset, then read_enable pulse with comb_enable=0 -> 24 integ_step cycles (channel 0..7, stage 0,1,2 each), no comb_step/out_we, cic_finish at cycle 25 after strobe, busy low after.
- read_enable with comb_enable=1 -> per channel 3 integ_step, 3 comb_step, 1 out_we; 8 out_we pulses with channel 0..7; cic_finish at cycle 57.
- cfg_we with 31 during a non-comb sweep -> sample_rate stays 63; after next comb sweep's cic_finish cycle, sample_rate=31.
- cfg_we with 15 in the exact S_DONE apply cycle while pending_rate=31 -> sample_rate=31, next comb sweep yields 15.
- read_enable again at cycle 10 of a sweep -> sweep unaffected, overrun=1 until overrun_clr; overrun_clr coincident with new overrun -> stays 1.
- resetn asserted in S_COMB of channel 3 -> next cycle all outputs at reset values, sample_rate=63, no cic_finish; new strobe restarts at channel 0.
